// File: rtl/mem_pkg.sv
// Shared store-path types: access size, byte-enable constants, formatted store entry.
// Latency: n/a (types and pure combinational helper functions only).
// Backpressure: n/a.
package mem_pkg;

   // Address width the formatted entry carries; the top-level AW must match it.
   localparam int ADDR_W = 32;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } size_t;

   // Big-endian lanes: bit3 enables bits 31:24, which is byte offset 0.
   localparam logic [3:0] BE_NONE    = 4'b0000;
   localparam logic [3:0] BE_BYTE0   = 4'b1000;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_WORD    = 4'b1111;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
      logic [3:0]        be;
   } store_entry_t;

   // True when the access cannot be issued: misaligned half/word or illegal size.
   function automatic logic store_misaligned(input logic [1:0] addr_lo, input size_t size);
      logic bad;
      bad = 1'b1;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = addr_lo[0];
         SZ_WORD: bad = (addr_lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Narrow register data to the access size and replicate it onto every lane
   // it could occupy; the byte enables select the lane actually written.
   function automatic store_entry_t fmt_store(input logic [ADDR_W-1:0] addr,
                                              input logic [31:0]       data,
                                              input size_t             size);
      store_entry_t e;
      e.addr = {addr[ADDR_W-1:2], 2'b00};
      e.data = data;
      e.be   = BE_NONE;
      case (size)
         SZ_BYTE: begin
            e.data = {4{data[7:0]}};
            e.be   = BE_BYTE0 >> addr[1:0];
         end
         SZ_HALF: begin
            e.data = {2{data[15:0]}};
            e.be   = addr[1] ? BE_HALF_LO : BE_HALF_HI;
         end
         SZ_WORD: begin
            e.data = data;
            e.be   = BE_WORD;
         end
         default: begin
            e.data = data;
            e.be   = BE_NONE;
         end
      endcase
      return e;
   endfunction

endpackage

// File: rtl/store_queue.sv
// DEPTH-entry synchronous FIFO of formatted stores.
// Latency: an entry pushed at edge N is at the head after edge N (one cycle).
// Backpressure: push ignored when full, pop ignored when empty; simultaneous push/pop keeps count.
module store_queue
   import mem_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  store_entry_t  push_entry,
   input  logic          pop,
   output store_entry_t  head_entry,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   store_entry_t   mem_q [DEPTH];
   store_entry_t   mem_d [DEPTH];
   logic [PW-1:0]  head_q, head_d;
   logic [PW-1:0]  tail_q, tail_d;
   logic [CW-1:0]  count_q, count_d;
   logic           do_push;
   logic           do_pop;

   assign full       = (count_q == CW'(DEPTH));
   assign empty      = (count_q == '0);
   assign count      = count_q;
   assign head_entry = mem_q[head_q];
   assign do_push    = push && !full;
   assign do_pop     = pop && !empty;

   // Next-state: write at tail, advance pointers (natural wrap, DEPTH is a power of two), track occupancy.
   always_comb begin
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (do_push) begin
         mem_d[tail_q] = push_entry;
         tail_d        = tail_q + 1'b1;
      end
      if (do_pop) begin
         head_d = head_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // State registers; reset flushes every entry so nothing stale can surface.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/store_formatter.sv
// Formats byte/half/word stores onto big-endian lanes, queues them, flags misaligned stores.
// Latency: accepted store appears on Mem* one cycle after the accepting edge.
// Backpressure: ReqReady drops when the queue is full (no same-cycle pass-through); Mem* held while !MemReady.
module store_formatter
   import mem_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int AW    = ADDR_W
) (
   input  logic          Clock,
   input  logic          nReset,
   input  logic          ReqValid,
   output logic          ReqReady,
   input  logic [AW-1:0] Addr,
   input  logic [31:0]   Data,
   input  logic [1:0]    Size,
   output logic          MemValid,
   input  logic          MemReady,
   output logic [AW-1:0] MemAddr,
   output logic [31:0]   MemData,
   output logic [3:0]    MemBE,
   output logic          AddrErr,
   output logic [AW-1:0] BadAddr,
   output logic          Busy
);

   localparam int CW = $clog2(DEPTH + 1);

   size_t          req_size;
   logic           accept;
   logic           req_err;
   store_entry_t   req_entry;
   store_entry_t   head_entry;
   logic           q_push;
   logic           q_pop;
   logic           q_full;
   logic           q_empty;
   logic [CW-1:0]  q_count;

   logic           addr_err_q, addr_err_d;
   logic [AW-1:0]  bad_addr_q, bad_addr_d;

   assign req_size  = size_t'(Size);
   assign accept    = ReqValid && ReqReady;
   assign req_err   = store_misaligned(Addr[1:0], req_size);
   assign req_entry = fmt_store(Addr, Data, req_size);

   // Rejected requests still complete the handshake but never enter the queue.
   assign q_push = accept && !req_err;
   assign q_pop  = MemValid && MemReady;

   store_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk        (Clock),
      .rst_n      (nReset),
      .push       (q_push),
      .push_entry (req_entry),
      .pop        (q_pop),
      .head_entry (head_entry),
      .full       (q_full),
      .empty      (q_empty),
      .count      (q_count)
   );

   assign ReqReady = !q_full;
   assign MemValid = !q_empty;
   assign Busy     = (q_count != '0);

   // Idle outputs read as zero so a freshly reset or drained port shows no leftover store.
   assign MemAddr = q_empty ? '0 : head_entry.addr;
   assign MemData = q_empty ? '0 : head_entry.data;
   assign MemBE   = q_empty ? '0 : head_entry.be;

   assign AddrErr = addr_err_q;
   assign BadAddr = bad_addr_q;

   // Error pulse lasts the cycle after a rejected accept; faulting address is kept until the next error.
   always_comb begin
      addr_err_d = accept && req_err;
      bad_addr_d = bad_addr_q;
      if (accept && req_err) begin
         bad_addr_d = Addr;
      end
   end

   // Error reporting registers.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         addr_err_q <= 1'b0;
         bad_addr_q <= '0;
      end else begin
         addr_err_q <= addr_err_d;
         bad_addr_q <= bad_addr_d;
      end
   end

endmodule
